// File: rtl/regfile_wb_arbiter.sv
// Round-robin writeback arbiter between execute (A) and load return (B),
// feeding a registered register-file write port and an issued-write counter.
module regfile_wb_arbiter #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hold,
  input  logic              a_valid,
  input  logic [4:0]        a_rd,
  input  logic [DATA_W-1:0] a_data,
  output logic              a_ready,
  input  logic              b_valid,
  input  logic [4:0]        b_rd,
  input  logic [DATA_W-1:0] b_data,
  output logic              b_ready,
  output logic              RegWEn,
  output logic [4:0]        rsW,
  output logic [DATA_W-1:0] dataW,
  output logic [CNT_W-1:0]  wr_count
);

  logic              r_last_b;
  logic              r_we;
  logic [4:0]        r_rd;
  logic [DATA_W-1:0] r_data;
  logic [CNT_W-1:0]  r_cnt;

  logic              w_open;
  logic              w_grant_a;
  logic              w_grant_b;
  logic              w_xfer;
  logic              w_we;
  logic [4:0]        w_rd;
  logic [DATA_W-1:0] w_data;

  // r_last_b set means B won last, so A takes the next contention
  assign w_open    = !rst && !hold;
  assign w_grant_a = w_open && a_valid && (!b_valid || r_last_b);
  assign w_grant_b = w_open && b_valid && (!a_valid || !r_last_b);
  assign w_xfer    = w_grant_a || w_grant_b;

  always_comb begin
    w_rd   = 5'd0;
    w_data = '0;
    unique case (1'b1)
      w_grant_a: begin
        w_rd   = a_rd;
        w_data = a_data;
      end
      w_grant_b: begin
        w_rd   = b_rd;
        w_data = b_data;
      end
      default: begin
        w_rd   = 5'd0;
        w_data = '0;
      end
    endcase
  end

  // x0 transfers are accepted but never reach the register file
  assign w_we = w_xfer && (w_rd != 5'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last_b <= 1'b1;
      r_we     <= 1'b0;
      r_rd     <= 5'd0;
      r_data   <= '0;
      r_cnt    <= '0;
    end else begin
      if (w_xfer) begin
        r_last_b <= w_grant_b;
      end
      r_we <= w_we;
      if (w_we) begin
        r_rd   <= w_rd;
        r_data <= w_data;
        r_cnt  <= r_cnt + 1'b1;
      end
    end
  end

  assign a_ready  = w_grant_a;
  assign b_ready  = w_grant_b;
  assign RegWEn   = r_we;
  assign rsW      = r_rd;
  assign dataW    = r_data;
  assign wr_count = r_cnt;

endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 Parameter: DATA_W, 32, width of write data and of both requester data buses.
REQ-002 Parameter: CNT_W, 16, width of the issued-write counter.
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: rst  input  1  reset, asynchronous and active-high.
REQ-005 Port: hold  input  1  stall request; while 1, no requester is granted.
REQ-006 Port: a_valid  input  1  requester A (execute writeback) has a write pending.
REQ-007 Port: a_rd  input  5  requester A destination register.
REQ-008 Port: a_data  input  DATA_W  requester A write data.
REQ-009 Port: a_ready  output  1  requester A write accepted this cycle.
REQ-010 Port: b_valid  input  1  requester B (load return) has a write pending.
REQ-011 Port: b_rd  input  5  requester B destination register.
REQ-012 Port: b_data  input  DATA_W  requester B write data.
REQ-013 Port: b_ready  output  1  requester B write accepted this cycle.
REQ-014 Port: RegWEn  output  1  register-file write enable, registered.
REQ-015 Port: rsW  output  5  register-file write address, registered.
REQ-016 Port: dataW  output  DATA_W  register-file write data, registered.
REQ-017 Port: wr_count  output  CNT_W  count of writes issued to the register file.

Function
REQ-018 Handshake: a transfer on a requester occurs in a cycle where its valid and ready are both 1; requester SHALL hold valid, rd, data stable until transfer.
REQ-019 a_ready and b_ready SHALL be combinational from valids, hold, rst and the priority pointer; at most one of them is 1 in any cycle.
REQ-020 hold=1 or rst=1: a_ready=b_ready=0.
REQ-021 hold=0, only one valid: that requester SHALL be granted in the same cycle.
REQ-022 hold=0, both valid: grant the requester opposite to the priority pointer's last-granted value (round-robin).
REQ-023 Priority pointer SHALL update to the granted requester on every transfer, including x0 transfers; unchanged when no transfer.
REQ-024 Transfer with rd!=0: on the next rising edge RegWEn=1, rsW=rd, dataW=data of the granted requester; latency exactly 1 cycle.
REQ-025 Transfer with rd=0: accepted (ready=1) but next cycle RegWEn=0; rsW/dataW unchanged; wr_count unchanged.
REQ-026 Cycle with no transfer: next cycle RegWEn=0; rsW and dataW SHALL hold their previous values.
REQ-027 RegWEn SHALL be 1 for exactly one cycle per non-x0 transfer; back-to-back transfers produce back-to-back write cycles with no bubble.
REQ-028 wr_count SHALL increment by 1 on each cycle RegWEn is driven 1, wrapping from 2^CNT_W-1 to 0.
REQ-029 Both requesters targeting the same rd: writes SHALL be issued in grant order, one per cycle; last granted value is final.
REQ-030 Non-granted valid requester SHALL wait at most one cycle while the other stays valid and hold=0 (starvation-free).
REQ-031 hold asserted while a write is in the output register: that registered write still completes (RegWEn=1 that cycle); only new grants are blocked.

Reset
REQ-032 rst=1 SHALL asynchronously force RegWEn=0, rsW=0, dataW=0, wr_count=0 and pointer=B-last (so A wins the first contention).
REQ-033 rst asserted mid-operation SHALL discard any write in the output register (RegWEn=0 immediately); no write issued in the cycle after deassertion unless a new transfer occurs.

Verification
REQ-034 Reset then a_valid=1, a_rd=3, a_data=55 for one cycle -> a_ready=1 that cycle; next cycle RegWEn=1, rsW=3, dataW=55; wr_count=1.
REQ-035 a_valid and b_valid both held 1 (a_rd=4/data=10, b_rd=5/data=20) for 4 cycles after reset -> grants A,B,A,B; RegWEn high 4 consecutive cycles, rsW 4,5,4,5.
REQ-036 b_valid=1, b_rd=0, b_data=99 -> b_ready=1; next cycle RegWEn=0, dataW unchanged, wr_count unchanged.
REQ-037 hold=1 with a_valid=1 for 3 cycles -> a_ready=0, RegWEn=0 throughout; hold=0 -> grant same cycle, write next cycle.
REQ-038 rst pulsed while RegWEn=1 -> RegWEn, rsW, dataW, wr_count read 0 before next clock edge.
REQ-039 Preload wr_count to 0xFFFF via 65535 writes then one more write -> wr_count=0.
